sa_data_loader_gen: RTL and testbench
=====================================

Name: sa_data_loader_gen

Overview:
- Parametrised successor to the fixed 3x3 systolic-array (SA) data loader.
- Preloads an ARRAY_N x ARRAY_N weight tile into the SA, row by row, from a shared scratchpad.
- Streams a runtime-selected number of feature vectors into the SA, skewed diagonally per lane, then drains the array.
- Sits between the SA controller (start/mode/done handshake) and the scratchpad read port (1-cycle read latency).

Parameters:
- ARRAY_N, 3: SA dimension; number of lanes and weight rows.
- DATA_W, 8: element width.
- ADDR_W, 6: scratchpad address width. Addresses wrap mod 2^ADDR_W.
- MAX_VEC, 16: maximum feature vectors per job.
- CNT_W, 5: width of num_vec; must satisfy 2^CNT_W > MAX_VEC.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  job request; accepted only when busy=0.
- mode  in  1  0 = weight preload, 1 = feature load; sampled with start.
- base_addr  in  ADDR_W  first scratchpad row; latched at start.
- num_vec  in  CNT_W  feature vector count; latched at start; ignored in mode 0.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- mem_rd_en  out  1  scratchpad read strobe.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  ARRAY_N*DATA_W  row data, valid the cycle after mem_rd_en; lane i at bits [i*DATA_W +: DATA_W].
- preload_en  out  ARRAY_N  one-hot SA weight-row load enable.
- preload_weight  out  ARRAY_N*DATA_W  weight row being loaded.
- feature_o  out  ARRAY_N*DATA_W  skewed feature lanes.
- feature_vld  out  ARRAY_N  per-lane valid.
- sa_en  out  1  SA compute enable.

Behaviour:
- Cycle numbering: the rising edge that accepts start is edge 0; cycle c is the interval after edge c.
- Reset: every output is 0; FSM goes to IDLE; skew registers are cleared. Reset mid-job aborts the job with no done pulse.
- FSM states: IDLE, WREQ, FREQ, DRAIN, DONE.
  - IDLE -> WREQ on start with mode=0.
  - IDLE -> FREQ on start with mode=1.
  - DONE -> IDLE after one cycle.
- start is ignored while busy=1.
- busy=1 in every state except IDLE and DONE.
- A start in the DONE cycle is accepted, because busy=0 in that cycle.
- Weight preload (mode 0):
  - Cycles 1..N: mem_rd_en=1, mem_addr=base+(c-1).
  - Cycles 2..N+1: preload_en = one-hot bit (c-2), preload_weight = mem_rdata.
  - Cycle N+2: done=1.
  - feature_o, feature_vld and sa_en stay 0.
- Feature load (mode 1), with V = min(num_vec, MAX_VEC):
  - Cycles 1..V: mem_rd_en=1, mem_addr=base+(c-1).
  - Returned row k enters the skew buffer in cycle k+2.
  - Lane i is delayed by i additional cycles, so lane i has feature_vld[i]=1 in cycles 2+i .. V+1+i.
  - feature_o lane i = 0 whenever feature_vld[i]=0.
  - sa_en=1 in cycles 2 .. V+2N-1; the final N-1 cycles are DRAIN, for partial-sum exit.
  - done in cycle V+2N.
  - preload_en stays 0.
- num_vec=0: no reads, sa_en stays 0; busy in cycle 1 only; done in cycle 2.
- num_vec > MAX_VEC is clamped to MAX_VEC.
- Address arithmetic is unsigned ADDR_W-bit and wraps silently.
- mem_rd_en is never asserted in IDLE or DONE.

Decomposition:
- Package sa_loader_pkg holds:
  - the state enum;
  - constants MODE_WEIGHT=1'b0 and MODE_FEATURE=1'b1;
  - a lane-slice helper function.
- Sub-module sa_skew_buffer (parameters ARRAY_N, DATA_W) implements the per-lane delay chains with valid.
  - Lane i uses i registers.
  - Clear on rst.

Test Plan:
1. Weight preload, N=3, base=0; memory row k holds lanes {3k+1, 3k+2, 3k+3}.
   -> Reads to addr 0,1,2 in cycles 1-3.
   -> preload_en = 001/010/100 with rows {1,2,3}/{4,5,6}/{7,8,9} in cycles 2-4.
   -> done in cycle 5; busy low from cycle 5.
2. Feature load, base=9, num_vec=3.
   -> Reads to addr 9,10,11.
   -> feature_vld[0] in cycles 2-4, [1] in 3-5, [2] in 4-6.
   -> sa_en in cycles 2-8; done in cycle 9.
3. Back-to-back jobs: start+mode=1 asserted in the done cycle of a weight job.
   -> The new job is accepted, with its first read in the following cycle.
   -> A start pulse during busy causes no effect.
4. Address wrap: weight job with base=62.
   -> mem_addr = 62, 63, 0.
5. Reset mid feature load (asserted in cycle 4).
   -> All outputs 0 immediately; no done.
   -> A fresh start after release behaves exactly as scenario 2.
6. Count edge cases.
   -> num_vec=0: done in cycle 2, no mem_rd_en, no sa_en.
   -> num_vec=20: exactly 16 reads, done in cycle 22.

Source files
------------

// File: rtl/sa_loader_pkg.sv
// Shared types and helpers for the systolic-array data loader.
// Holds the FSM state enum, job-mode codes and a lane-slice function.
package sa_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREQ,
    S_FREQ,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic MODE_WEIGHT  = 1'b0;
  localparam logic MODE_FEATURE = 1'b1;

  localparam int BUS_MAX  = 256;
  localparam int LANE_MAX = 32;

  // Returns lane idx of a packed bus of w-bit lanes (caller truncates).
  function automatic logic [LANE_MAX-1:0] lane_sel(
    input logic [BUS_MAX-1:0] bus,
    input int unsigned        idx,
    input int unsigned        w
  );
    logic [BUS_MAX-1:0] s;
    s = bus >> (idx * w);
    return s[LANE_MAX-1:0];
  endfunction

endpackage

// File: rtl/sa_skew_buffer.sv
// Diagonal skew for SA feature lanes: lane i is delayed by i registers.
// Ports: din_i/vld_i row in, dout_o/vld_o skewed lanes (data zeroed when invalid).
module sa_skew_buffer
  import sa_loader_pkg::*;
#(
  parameter int ARRAY_N = 3,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ARRAY_N*DATA_W-1:0] din_i,
  input  logic                      vld_i,
  output logic [ARRAY_N*DATA_W-1:0] dout_o,
  output logic [ARRAY_N-1:0]        vld_o
);

  for (genvar i = 0; i < ARRAY_N; i++) begin : g_lane
    logic [DATA_W-1:0] lin;
    assign lin = DATA_W'(lane_sel(BUS_MAX'(din_i), i, DATA_W));

    if (i == 0) begin : g_pass
      assign vld_o[0]          = vld_i;
      assign dout_o[0+:DATA_W] = vld_i ? lin : '0;
    end else begin : g_dly
      logic [DATA_W-1:0] d_q [i];
      logic [i-1:0]      v_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < i; k++) d_q[k] <= '0;
          v_q <= '0;
        end else begin
          d_q[0] <= lin;
          v_q[0] <= vld_i;
          for (int k = 1; k < i; k++) begin
            d_q[k] <= d_q[k-1];
            v_q[k] <= v_q[k-1];
          end
        end
      end

      assign vld_o[i]               = v_q[i-1];
      assign dout_o[i*DATA_W+:DATA_W] = v_q[i-1] ? d_q[i-1] : '0;
    end
  end

endmodule

// File: rtl/sa_data_loader_gen.sv
// SA data loader: weight-tile preload and skewed feature streaming.
// Ports: start/mode/base_addr/num_vec job in, busy/done status, scratchpad read, SA feeds.
module sa_data_loader_gen
  import sa_loader_pkg::*;
#(
  parameter int ARRAY_N = 3,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int MAX_VEC = 16,
  parameter int CNT_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [CNT_W-1:0]          num_vec,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [ARRAY_N*DATA_W-1:0] mem_rdata,
  output logic [ARRAY_N-1:0]        preload_en,
  output logic [ARRAY_N*DATA_W-1:0] preload_weight,
  output logic [ARRAY_N*DATA_W-1:0] feature_o,
  output logic [ARRAY_N-1:0]        feature_vld,
  output logic                      sa_en
);

  localparam int CW = $clog2(MAX_VEC + 2*ARRAY_N + 1);

  state_e            st_q, st_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  nv_q, nv_clamp;
  logic [CW-1:0]     v_ext;
  logic              accept;

  logic              busy_d, done_d, rd_d, sa_d, frd_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ARRAY_N-1:0] pl1_d;

  logic              busy_q, done_q, rd_q, sa_q, f1_q, fv_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ARRAY_N-1:0] pl1_q, pl_q;

  assign accept   = (st_q == S_IDLE) && start;
  assign nv_clamp = (num_vec > CNT_W'(MAX_VEC)) ? CNT_W'(MAX_VEC) : num_vec;
  assign v_ext    = CW'(nv_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      base_q <= '0;
      nv_q   <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      if (accept) begin
        base_q <= base_addr;
        nv_q   <= nv_clamp;
      end
    end
  end

  // FREQ runs V read cycles plus N fill cycles; DRAIN covers N-1 more.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start)
          st_d = (mode == MODE_FEATURE) ? S_FREQ : S_WREQ;
      end
      S_WREQ: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ARRAY_N)) st_d = S_DONE;
      end
      S_FREQ: begin
        cnt_d = cnt_q + 1'b1;
        if (v_ext == '0)
          st_d = S_DONE;
        else if (cnt_q == v_ext + CW'(ARRAY_N-1))
          st_d = (ARRAY_N > 1) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == v_ext + CW'(2*ARRAY_N-2)) st_d = S_DONE;
      end
      S_DONE:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so each state shows up one cycle later.
  always_comb begin
    busy_d = st_q inside {S_WREQ, S_FREQ, S_DRAIN};
    done_d = (st_q == S_DONE);
    frd_d  = (st_q == S_FREQ) && (cnt_q < v_ext);
    rd_d   = frd_d ||
             ((st_q == S_WREQ) && (cnt_q < CW'(ARRAY_N)));
    addr_d = rd_d ? base_q + ADDR_W'(cnt_q) : '0;
    sa_d   = ((st_q == S_FREQ) && (cnt_q != '0)) ||
             (st_q == S_DRAIN);
    pl1_d  = '0;
    if ((st_q == S_WREQ) && (cnt_q < CW'(ARRAY_N)))
      pl1_d = ARRAY_N'(1) << cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= '0;
      sa_q   <= 1'b0;
      pl1_q  <= '0;
      pl_q   <= '0;
      f1_q   <= 1'b0;
      fv_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      rd_q   <= rd_d;
      addr_q <= addr_d;
      sa_q   <= sa_d;
      pl1_q  <= pl1_d;
      pl_q   <= pl1_q;
      f1_q   <= frd_d;
      fv_q   <= f1_q;
    end
  end

  sa_skew_buffer #(
    .ARRAY_N(ARRAY_N),
    .DATA_W (DATA_W)
  ) u_skew (
    .clk   (clk),
    .rst   (rst),
    .din_i (mem_rdata),
    .vld_i (fv_q),
    .dout_o(feature_o),
    .vld_o (feature_vld)
  );

  assign busy           = busy_q;
  assign done           = done_q;
  assign mem_rd_en      = rd_q;
  assign mem_addr       = addr_q;
  assign sa_en          = sa_q;
  assign preload_en     = pl_q;
  assign preload_weight = (|pl_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_sa_data_loader_gen.sv
// Directed bench for sa_data_loader_gen (N=3, 8-bit lanes, 6-bit addr).
// Scratchpad row a holds lanes {3a+1, 3a+2, 3a+3}, lane 0 in low bits.
module tb_sa_data_loader_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [5:0]  base_addr = '0;
  logic [4:0]  num_vec = '0;
  logic        busy, done, mem_rd_en, sa_en;
  logic [5:0]  mem_addr;
  logic [23:0] mem_rdata = '0;
  logic [2:0]  preload_en, feature_vld;
  logic [23:0] preload_weight, feature_o;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic        r_rd [512];
  logic [5:0]  r_ad [512];
  logic [2:0]  r_pe [512];
  logic [23:0] r_pw [512];
  logic [23:0] r_fo [512];
  logic [2:0]  r_fv [512];
  logic        r_sa [512];
  logic        r_bz [512];
  logic        r_dn [512];

  always #5 clk = ~clk;

  sa_data_loader_gen dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .base_addr(base_addr), .num_vec(num_vec),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .preload_en(preload_en), .preload_weight(preload_weight),
    .feature_o(feature_o), .feature_vld(feature_vld), .sa_en(sa_en)
  );

  function automatic logic [23:0] row(input int a);
    int k;
    k = a & 63;
    return {8'(3*k+3), 8'(3*k+2), 8'(3*k+1)};
  endfunction

  always @(posedge clk)
    if (mem_rd_en) mem_rdata <= row(int'(mem_addr));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    r_rd[cyc] = mem_rd_en; r_ad[cyc] = mem_addr;
    r_pe[cyc] = preload_en; r_pw[cyc] = preload_weight;
    r_fo[cyc] = feature_o; r_fv[cyc] = feature_vld;
    r_sa[cyc] = sa_en; r_bz[cyc] = busy; r_dn[cyc] = done;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic go(input logic m, input int b, input int nv,
                    output int t0);
    start = 1'b1; mode = m;
    base_addr = 6'(b); num_vec = 5'(nv);
    step();
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic chk_zero(input string tg);
    chk({tg, " busy"}, 32'(busy), 0);
    chk({tg, " done"}, 32'(done), 0);
    chk({tg, " rd"}, 32'(mem_rd_en), 0);
    chk({tg, " addr"}, 32'(mem_addr), 0);
    chk({tg, " pe"}, 32'(preload_en), 0);
    chk({tg, " pw"}, 32'(preload_weight), 0);
    chk({tg, " fo"}, 32'(feature_o), 0);
    chk({tg, " fv"}, 32'(feature_vld), 0);
    chk({tg, " sa"}, 32'(sa_en), 0);
  endtask

  task automatic chk_w(input string tg, input int t0, input int b,
                       input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      int t;
      logic e_rd;
      logic [2:0] e_pe;
      string s;
      t = t0 + c;
      s = $sformatf("%s c%0d", tg, c);
      e_rd = (c >= 1 && c <= 3);
      e_pe = (c >= 2 && c <= 4) ? 3'(1 << (c-2)) : 3'b0;
      chk({s, " rd"}, 32'(r_rd[t]), 32'(e_rd));
      if (e_rd) chk({s, " addr"}, 32'(r_ad[t]), 32'((b + c - 1) & 63));
      chk({s, " pe"}, 32'(r_pe[t]), 32'(e_pe));
      if (e_pe != 0) chk({s, " pw"}, 32'(r_pw[t]), 32'(row(b + c - 2)));
      chk({s, " busy"}, 32'(r_bz[t]), 32'(c >= 1 && c <= 4));
      chk({s, " done"}, 32'(r_dn[t]), 32'(c == 5));
      chk({s, " sa"}, 32'(r_sa[t]), 0);
      chk({s, " fv"}, 32'(r_fv[t]), 0);
      chk({s, " fo"}, 32'(r_fo[t]), 0);
    end
  endtask

  task automatic chk_f(input string tg, input int t0, input int b,
                       input int nv, input int c0, input int c1);
    int v;
    v = (nv > 16) ? 16 : nv;
    for (int c = c0; c <= c1; c++) begin
      int t;
      logic e_rd, e_bz, e_dn, e_sa;
      logic [2:0] e_fv;
      logic [23:0] e_fo, rw;
      string s;
      t = t0 + c;
      s = $sformatf("%s c%0d", tg, c);
      e_rd = (c >= 1 && c <= v);
      if (v == 0) begin
        e_bz = (c == 1); e_dn = (c == 2); e_sa = 1'b0;
      end else begin
        e_bz = (c >= 1 && c <= v + 5);
        e_dn = (c == v + 6);
        e_sa = (c >= 2 && c <= v + 5);
      end
      e_fv = '0; e_fo = '0;
      for (int i = 0; i < 3; i++)
        if (c >= 2 + i && c <= v + 1 + i) begin
          e_fv[i] = 1'b1;
          rw = row(b + c - 2 - i);
          e_fo[i*8+:8] = rw[i*8+:8];
        end
      chk({s, " rd"}, 32'(r_rd[t]), 32'(e_rd));
      if (e_rd) chk({s, " addr"}, 32'(r_ad[t]), 32'((b + c - 1) & 63));
      chk({s, " busy"}, 32'(r_bz[t]), 32'(e_bz));
      chk({s, " done"}, 32'(r_dn[t]), 32'(e_dn));
      chk({s, " sa"}, 32'(r_sa[t]), 32'(e_sa));
      chk({s, " fv"}, 32'(r_fv[t]), 32'(e_fv));
      chk({s, " fo"}, 32'(r_fo[t]), 32'(e_fo));
      chk({s, " pe"}, 32'(r_pe[t]), 0);
    end
  endtask

  initial begin
    int t0, t1, nrd;

    // reset state
    steps(2);
    chk_zero("rst");
    @(negedge clk);
    rst = 1'b1;
    steps(2);
    chk_zero("idle");

    // 1: weight preload, base 0
    go(1'b0, 0, 0, t0);
    steps(8);
    chk_w("w0", t0, 0, 0, 8);

    // 2: feature load, base 9, three vectors
    go(1'b1, 9, 3, t0);
    steps(12);
    chk_f("f9", t0, 9, 3, 0, 12);

    // 3: back-to-back, with a start pulse while busy
    go(1'b0, 0, 0, t0);
    step();
    step();
    start = 1'b1; mode = 1'b1; base_addr = 6'd30; num_vec = 5'd2;
    step();
    start = 1'b0;
    step();
    step();
    chk("b2b done", 32'(done), 1);
    chk("b2b busy", 32'(busy), 0);
    go(1'b1, 9, 3, t1);
    chk("b2b gap", 32'(t1 - t0), 6);
    steps(12);
    chk_w("bw", t0, 0, 0, 5);
    chk_f("bf", t1, 9, 3, 0, 12);

    // 4: address wrap
    go(1'b0, 62, 0, t0);
    steps(7);
    chk_w("wrap", t0, 62, 0, 7);

    // 5: reset in cycle 4 of a feature job
    go(1'b1, 9, 3, t0);
    steps(4);
    chk_f("pre", t0, 9, 3, 0, 4);
    rst = 1'b0;
    #1;
    chk_zero("arst");
    steps(2);
    chk_zero("hold");
    rst = 1'b1;
    nrd = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done || busy) nrd++;
    end
    chk("no done", 32'(nrd), 0);
    go(1'b1, 9, 3, t0);
    steps(12);
    chk_f("again", t0, 9, 3, 0, 12);

    // 6: count edges
    go(1'b1, 5, 0, t0);
    steps(6);
    chk_f("nv0", t0, 5, 0, 0, 6);
    go(1'b1, 40, 20, t0);
    steps(25);
    chk_f("nv20", t0, 40, 20, 0, 25);
    nrd = 0;
    for (int c = 0; c <= 25; c++) nrd += int'(r_rd[t0 + c]);
    chk("nv20 reads", 32'(nrd), 16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
